// File: rtl/graph_isa_pkg.sv
// Shared definitions for the graph ISA.
//
// Contents:
//   OP_G_*        8-bit opcodes used by the graph scheduler
//   math_resp_e   response code returned by math_cmd_issuer
//   math_state_e  state encoding of math_cmd_issuer (exposed on its debug port)
//   is_math_op()  true for the opcodes the LUT math engine executes
package graph_isa_pkg;

    // Opcodes. Only the transcendental group runs on the LUT math engine;
    // the arithmetic ones live here because they share the opcode space.
    localparam logic [7:0] OP_G_ADD   = 8'h01;
    localparam logic [7:0] OP_G_MUL   = 8'h02;
    localparam logic [7:0] OP_G_EXP   = 8'h10;
    localparam logic [7:0] OP_G_LOG   = 8'h11;
    localparam logic [7:0] OP_G_SQRT  = 8'h12;
    localparam logic [7:0] OP_G_RSQRT = 8'h13;

    typedef enum logic [1:0] {
        ME_RESP_OK      = 2'd0,
        ME_RESP_BAD_OP  = 2'd1,
        ME_RESP_TIMEOUT = 2'd2
    } math_resp_e;

    typedef enum logic [2:0] {
        MS_IDLE      = 3'd0,
        MS_CHECK     = 3'd1,
        MS_ISSUE     = 3'd2,
        MS_WAIT_DONE = 3'd3,
        MS_RESP      = 3'd4
    } math_state_e;

    function automatic logic is_math_op(input logic [7:0] opcode);
        logic r;
        r = 1'b0;
        case (opcode)
            OP_G_EXP, OP_G_LOG, OP_G_SQRT, OP_G_RSQRT: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/math_cmd_issuer.sv
// Command-side initiator for the LUT math engine.
//
// Takes element-wise math jobs from the graph scheduler, splits each one into
// chunks of at most CHUNK_LEN elements, issues one engine command per chunk,
// waits for the engine's done pulse, and returns one response per job.
//
// Handshakes (all sampled on posedge clk):
//   job:  a job transfers on any edge where job_valid && job_ready; job_ready
//         is high only in IDLE, so the scheduler may hold job_valid freely.
//   resp: resp_valid is held with stable fields until an edge where
//         resp_ready is also high; resp_valid drops after that edge.
//   cmd:  cmd_valid is a single-cycle strobe with no back-pressure; it is only
//         raised after eng_busy was seen low, and only one command is ever
//         outstanding.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   job_valid/job_ready       job request handshake
//   job_opcode/src/dst/length job fields (latched on accept)
//   cmd_valid/opcode/src_base/dst_base/length   engine command (registered)
//   eng_busy, eng_done        engine status and one-cycle done pulse
//   resp_valid/resp_ready     response handshake
//   resp_err, resp_chunks     response code and number of completed chunks
//   busy                      high whenever the FSM is not in IDLE
//   state_dbg                 current FSM state
module math_cmd_issuer
    import graph_isa_pkg::*;
#(
    parameter int CHUNK_LEN   = 256,   // 1..32768
    parameter int TIMEOUT_CYC = 4096   // >= 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_opcode,
    input  logic [15:0] job_src_base,
    input  logic [15:0] job_dst_base,
    input  logic [15:0] job_length,

    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [15:0] cmd_src_base,
    output logic [15:0] cmd_dst_base,
    output logic [15:0] cmd_length,
    input  logic        eng_busy,
    input  logic        eng_done,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_err,
    output logic [15:0] resp_chunks,

    output logic        busy,
    output math_state_e state_dbg
);

    // The timer only has to reach TIMEOUT_CYC-1.
    localparam int              TW         = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     CHUNK_MAX  = 16'(CHUNK_LEN);

    math_state_e   state_q;
    math_state_e   state_d;

    logic [7:0]    op_q;
    logic [15:0]   src_q;
    logic [15:0]   dst_q;
    logic [15:0]   remaining_q;
    logic [15:0]   offset_q;
    logic [15:0]   chunks_q;
    logic [TW-1:0] timer_q;
    math_resp_e    err_q;

    logic          job_accept;
    logic [15:0]   chunk_len;
    logic          timer_expired;
    logic          last_chunk;

    assign job_accept    = job_valid && (state_q == MS_IDLE);
    // Never zero here: ISSUE is only reached with remaining_q != 0.
    assign chunk_len     = (remaining_q > CHUNK_MAX) ? CHUNK_MAX : remaining_q;
    assign timer_expired = (timer_q == TIMER_LAST);
    // cmd_length holds the length of the chunk currently in flight.
    assign last_chunk    = (remaining_q == cmd_length);

    assign job_ready   = (state_q == MS_IDLE);
    assign busy        = (state_q != MS_IDLE);
    assign resp_valid  = (state_q == MS_RESP);
    // Response fields read as zero outside RESP so stale results never leak.
    assign resp_err    = (state_q == MS_RESP) ? err_q    : ME_RESP_OK;
    assign resp_chunks = (state_q == MS_RESP) ? chunks_q : 16'd0;
    assign state_dbg   = state_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: begin
                if (job_accept) state_d = MS_CHECK;
            end
            MS_CHECK: begin
                if (!is_math_op(op_q))      state_d = MS_RESP;
                else if (remaining_q == '0) state_d = MS_RESP;
                else                        state_d = MS_ISSUE;
            end
            MS_ISSUE: begin
                if (!eng_busy) state_d = MS_WAIT_DONE;
            end
            MS_WAIT_DONE: begin
                // A done arriving on the last timer cycle still counts.
                if (eng_done)           state_d = last_chunk ? MS_RESP : MS_ISSUE;
                else if (timer_expired) state_d = MS_RESP;
            end
            MS_RESP: begin
                if (resp_ready) state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    // State register plus job, chunk and timer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MS_IDLE;
            op_q         <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            offset_q     <= '0;
            chunks_q     <= '0;
            timer_q      <= '0;
            err_q        <= ME_RESP_OK;
            cmd_valid    <= 1'b0;
            cmd_opcode   <= '0;
            cmd_src_base <= '0;
            cmd_dst_base <= '0;
            cmd_length   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_valid <= 1'b0;

            case (state_q)
                MS_IDLE: begin
                    if (job_accept) begin
                        op_q        <= job_opcode;
                        src_q       <= job_src_base;
                        dst_q       <= job_dst_base;
                        remaining_q <= job_length;
                        offset_q    <= '0;
                        chunks_q    <= '0;
                        err_q       <= ME_RESP_OK;
                    end
                end
                MS_CHECK: begin
                    // Opcode is judged before length, so a bad opcode with
                    // length 0 still reports BAD_OP.
                    if (!is_math_op(op_q)) err_q <= ME_RESP_BAD_OP;
                    else                   err_q <= ME_RESP_OK;
                end
                MS_ISSUE: begin
                    if (!eng_busy) begin
                        cmd_valid    <= 1'b1;
                        cmd_opcode   <= op_q;
                        cmd_src_base <= src_q + offset_q;   // wraps mod 2^16
                        cmd_dst_base <= dst_q + offset_q;
                        cmd_length   <= chunk_len;
                        timer_q      <= '0;
                    end
                end
                MS_WAIT_DONE: begin
                    if (eng_done) begin
                        chunks_q    <= chunks_q + 16'd1;
                        offset_q    <= offset_q + cmd_length;
                        remaining_q <= remaining_q - cmd_length;
                    end else if (timer_expired) begin
                        err_q <= ME_RESP_TIMEOUT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
